double_eq_arbiter: RTL and testbench

//   Shares one double_eq comparator (combinational or dq-delayed) among
//   N_REQ requesters. Round-robin issue, one compare per cycle, tags each

---
 rtl/double_eq_arbiter.sv | 146 ++++++++++++++
 tb/tb_double_eq_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_eq_arbiter.sv
// Round-robin arbiter that shares one double-precision equality comparator among N_REQ requesters.
// Define DOUBLE_EQ_ARB_FIXED_PRIO_EN to use fixed priority (lowest eligible index wins) instead of round-robin.
module double_eq_arbiter #(
    parameter int N_REQ       = 4,
    parameter int CMP_LATENCY = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [64*N_REQ-1:0]  req_a,
    input  logic [64*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [N_REQ-1:0]     rsp_z,
    output logic [63:0]          cmp_a,
    output logic [63:0]          cmp_b,
    input  logic                 cmp_z,
    output logic                 cmp_issue
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PD = CMP_LATENCY + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // A requester keeps its operands stable while req_valid is high and not yet accepted;
    // rsp_valid/rsp_z hold until rsp_ready. Each requester has at most one compare in flight.
    logic [N_REQ-1:0] busy_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [N_REQ-1:0] rsp_z_q;
    logic [63:0]      cmp_a_q;
    logic [63:0]      cmp_b_q;
    logic             cmp_issue_q;
    logic             tag_v_q   [PD];
    logic [IW-1:0]    tag_idx_q [PD];

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] accept;
    logic [N_REQ-1:0] ret_hot;
    logic [N_REQ-1:0] rsp_fire;
    logic [IW-1:0]    sel_idx;
    logic [63:0]      sel_a;
    logic [63:0]      sel_b;
    logic             found;

`ifndef DOUBLE_EQ_ARB_FIXED_PRIO_EN
    logic [IW-1:0]    rr_q;
    logic [IW-1:0]    rr_d;
`endif

    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        sel_idx  = '0;
        eligible = req_valid & ~busy_q;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef DOUBLE_EQ_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
`endif
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                sel_idx    = IW'(idx);
            end
        end
    end

    // No grant may be seen while reset is asserted, even if requesters are already valid.
    assign req_ready = rst_n ? grant : '0;
    assign accept    = req_valid & req_ready;
    assign rsp_fire  = rsp_valid_q & rsp_ready;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[64*i +: 64];
                sel_b = req_b[64*i +: 64];
            end
        end
    end

    always_comb begin
        ret_hot = '0;
        if (tag_v_q[PD-1]) ret_hot[tag_idx_q[PD-1]] = 1'b1;
    end

`ifndef DOUBLE_EQ_ARB_FIXED_PRIO_EN
    always_comb begin
        rr_d = rr_q;
        if (|accept) rr_d = (sel_idx == IW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= '0;
        else        rr_q <= rr_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_z_q     <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_issue_q <= 1'b0;
            for (int s = 0; s < PD; s++) begin
                tag_v_q[s]   <= 1'b0;
                tag_idx_q[s] <= '0;
            end
        end else begin
            busy_q      <= (busy_q | accept) & ~rsp_fire;
            rsp_valid_q <= (rsp_valid_q & ~rsp_fire) | ret_hot;
            for (int i = 0; i < N_REQ; i++) begin
                if (ret_hot[i]) rsp_z_q[i] <= cmp_z;
            end
            cmp_issue_q <= |accept;
            if (|accept) begin
                cmp_a_q <= sel_a;
                cmp_b_q <= sel_b;
            end
            // Tag travels alongside the comparator so the result lands on the issuing requester.
            tag_v_q[0]   <= |accept;
            tag_idx_q[0] <= sel_idx;
            for (int s = 1; s < PD; s++) begin
                tag_v_q[s]   <= tag_v_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign cmp_issue = cmp_issue_q;

endmodule

// File: tb/tb_double_eq_arbiter.sv
// Bench for double_eq_arbiter: directed requests, a two-stage comparator model and a scoreboard monitor.
module tb_double_eq_arbiter;

    localparam int N = 4;
    localparam int L = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [64*N-1:0]  req_a;
    logic [64*N-1:0]  req_b;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [N-1:0]     rsp_z;
    logic [63:0]      cmp_a;
    logic [63:0]      cmp_b;
    logic             cmp_z;
    logic             cmp_issue;

    double_eq_arbiter #(.N_REQ(N), .CMP_LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_z     (cmp_z),
        .cmp_issue (cmp_issue)
    );

    localparam logic [63:0] ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] TWO  = 64'h4000000000000000;
    localparam logic [63:0] MONE = 64'hBFF0000000000000;
    localparam logic [63:0] PZ   = 64'h0000000000000000;
    localparam logic [63:0] NZ   = 64'h8000000000000000;
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] PINF = 64'h7FF0000000000000;
    localparam logic [63:0] NINF = 64'hFFF0000000000000;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [4:0]   exp_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- comparator model ----------------
    function automatic logic deq(input logic [63:0] a, input logic [63:0] b);
        if ((a[62:52] == 11'h7FF) && (a[51:0] != 52'd0)) return 1'b0;
        if ((b[62:52] == 11'h7FF) && (b[51:0] != 52'd0)) return 1'b0;
        if ((a[62:0] == 63'd0) && (b[62:0] == 63'd0)) return 1'b1;
        return a == b;
    endfunction

    logic zp [L];
    always @(posedge clk) begin
        zp[0] <= deq(cmp_a, cmp_b);
        for (int k = 1; k < L; k++) zp[k] <= zp[k-1];
    end
    assign cmp_z = zp[L-1];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] elig, input int ptr);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (r == '0 && elig[(ptr + k) % N]) r[(ptr + k) % N] = 1'b1;
        end
        return r;
    endfunction

    task automatic sb_pop(input int i, input logic z);
        int hit;
        hit = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (hit < 0 && exp_q[k][4:1] == 4'(i)) hit = k;
        end
        chk("sb_expected_present", 64'(hit >= 0), 64'd1);
        if (hit >= 0) begin
            chk("sb_rsp_z", 64'(z), 64'(exp_q[hit][0]));
            exp_q.delete(hit);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [N-1:0] busy_m;
    logic [N-1:0] rv_prev;
    logic [N-1:0] rdy_prev;
    logic [N-1:0] z_prev;
    int           rr_m;
    int           acc_edge [N];
    bit           acc_prev;
    bit           acc_now;
    logic [63:0]  a_prev;
    logic [63:0]  b_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_m   = '0;
            rv_prev  = '0;
            rdy_prev = '0;
            z_prev   = '0;
            rr_m     = 0;
            acc_prev = 1'b0;
        end else begin
            chk("grant", 64'(req_ready), 64'(model_grant(req_valid & ~busy_m, rr_m)));
            chk("cmp_issue", 64'(cmp_issue), 64'(acc_prev));
            if (acc_prev) begin
                chk("cmp_a", cmp_a, a_prev);
                chk("cmp_b", cmp_b, b_prev);
            end
            for (int i = 0; i < N; i++) begin
                if (rv_prev[i] && !rdy_prev[i]) begin
                    chk("rsp_hold_valid", 64'(rsp_valid[i]), 64'd1);
                    chk("rsp_hold_z", 64'(rsp_z[i]), 64'(z_prev[i]));
                end
                if (rsp_valid[i] && !rv_prev[i])
                    chk("rsp_latency", 64'(cyc - acc_edge[i]), 64'(L + 1));
                if (rsp_valid[i] && rsp_ready[i]) begin
                    sb_pop(i, rsp_z[i]);
                    busy_m[i] = 1'b0;
                end
            end
            acc_now = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    busy_m[i]   = 1'b1;
                    acc_edge[i] = cyc + 1;
                    acc_now     = 1'b1;
                    a_prev      = req_a[64*i +: 64];
                    b_prev      = req_b[64*i +: 64];
`ifndef DOUBLE_EQ_ARB_FIXED_PRIO_EN
                    rr_m        = (i + 1) % N;
`endif
                end
            end
            acc_prev = acc_now;
            rv_prev  = rsp_valid;
            rdy_prev = rsp_ready;
            z_prev   = rsp_z;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_acc(input int i);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        chk("accept_seen", 64'(ok), 64'd1);
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic z);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_valid[i]      = 1'b1;
        exp_q.push_back({4'(i), z});
    endtask

    task automatic send(input int i, input logic [63:0] a, input logic [63:0] b, input logic z);
        set_req(i, a, b, z);
        wait_acc(i);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int acc3;
    bit b0;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;

        // Reset state, with every requester already asking (also primes the all-valid test).
        set_req(0, ONE,  ONE,  1'b1);
        set_req(1, ONE,  TWO,  1'b0);
        set_req(2, PINF, PINF, 1'b1);
        set_req(3, QNAN, ONE,  1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_z",     64'(rsp_z),     64'd0);
        chk("reset_cmp_a",     cmp_a,          64'd0);
        chk("reset_cmp_b",     cmp_b,          64'd0);
        chk("reset_cmp_issue", 64'(cmp_issue), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All four valid from reset: accepted 0,1,2,3 on consecutive edges.
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("t3_order", 64'(req_ready), 64'd1 << k);
            @(posedge clk);
            #1;
            req_valid[k] = 1'b0;
        end
        wait_drain();

        // Single compares with IEEE corner cases.
        send(0, ONE,  ONE,  1'b1);
        wait_drain();
        send(1, PZ,   NZ,   1'b1);
        send(1, QNAN, QNAN, 1'b0);
        send(2, ONE,  TWO,  1'b0);
        send(3, NINF, NINF, 1'b1);
        wait_drain();

        // Requester 2 stalls its response; others keep issuing.
        rsp_ready[2] = 1'b0;
        send(2, PINF, PINF, 1'b1);
        set_req(2, 64'h1, 64'h1, 1'b1);
        fork
            begin
                send(0, ONE, 64'h3FF0000000000001, 1'b0);
                send(1, NZ, NZ, 1'b1);
                send(3, 64'hFFF8000000000000, 64'hFFF8000000000000, 1'b0);
                send(0, TWO, TWO, 1'b1);
            end
            begin
                repeat (4) @(negedge clk);
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("t4_req_ready2_low", 64'(req_ready[2]), 64'd0);
                    chk("t4_rsp_valid2_held", 64'(rsp_valid[2]), 64'd1);
                end
            end
        join
        @(posedge clk);
        #1;
        rsp_ready[2] = 1'b1;
        wait_acc(2);
        wait_drain();

        // Reset with two compares in flight.
        send(1, ONE, ONE, 1'b1);
        send(2, ONE, ONE, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t5_no_rsp_after_reset", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        set_req(0, 64'h7FF0000000000001, 64'h7FF0000000000001, 1'b0);
        set_req(3, NZ, PZ, 1'b1);
        @(negedge clk);
        chk("t5_rr_after_reset", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_acc(3);
        wait_drain();

        // Requesters 0 and 3 valid continuously.
        req_a[63:0]    = ONE;
        req_b[63:0]    = ONE;
        req_a[255:192] = ONE;
        req_b[255:192] = MONE;
        req_valid      = 4'b1001;
        acc3 = 0;
        b0   = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (req_ready[3]) begin
                acc3++;
`ifdef DOUBLE_EQ_ARB_FIXED_PRIO_EN
                chk("t6_req3_only_while_req0_busy", 64'(b0), 64'd1);
`endif
                exp_q.push_back({4'd3, 1'b0});
            end
            if (req_ready[0]) begin
                b0 = 1'b1;
                exp_q.push_back({4'd0, 1'b1});
            end
            if (rsp_valid[0] && rsp_ready[0]) b0 = 1'b0;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("t6_req3_accepted", 64'(acc3 > 0), 64'd1);
        wait_drain();

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
